// File: rtl/game_round_ctrl.sv
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Timed-round sequencer with score commit and result-page cycling.
//            Optional macro GAME_ROUND_CTRL_CLEAR_EN adds the clear_scores port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module game_round_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int GAME_SECS     = 30,
    parameter int SHOW_SECS     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] player_sel,
    input  logic [6:0] Current_Score,
`ifdef GAME_ROUND_CTRL_CLEAR_EN
    input  logic       clear_scores,
`endif
    output logic       game_timeout,
    output logic       tg1,
    output logic       tg2,
    output logic [6:0] Personel_Best,
    output logic [6:0] Highest_Score,
    output logic [2:0] Player_Won,
    output logic [5:0] secs_left,
    output logic       busy
);

    localparam int          TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]  GAME_LEN  = 6'(GAME_SECS);
    localparam logic [5:0]  SHOW_LAST = 6'(SHOW_SECS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        COMMIT   = 3'd2,
        SHOW_PB  = 3'd3,
        SHOW_HS  = 3'd4,
        SHOW_WIN = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [5:0]    page_secs;
    logic [1:0]    player;
    logic [6:0]    pb [4];

    logic tick_wrap, page_done, can_start, accept, clr, commit;

    assign tick_wrap = (tick_cnt == TICK_MAX);
    assign page_done = tick_wrap && (page_secs == SHOW_LAST);
    assign can_start = (state != PLAY) && (state != COMMIT);
    assign commit    = (state == COMMIT);
`ifdef GAME_ROUND_CTRL_CLEAR_EN
    assign clr       = clear_scores && can_start;
`else
    assign clr       = 1'b0;
`endif
    // A clear in the same cycle as start wins; the start request is dropped.
    assign accept    = start && can_start && !clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        game_timeout = 1'b1;
        tg1          = 1'b0;
        tg2          = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: ;
            PLAY: begin
                game_timeout = 1'b0;
                busy         = 1'b1;
                if (tick_wrap && secs_left == 6'd1) state_nxt = COMMIT;
            end
            COMMIT: begin
                busy      = 1'b1;
                state_nxt = SHOW_PB;
            end
            SHOW_PB: begin
                tg2 = 1'b1;
                if (page_done) state_nxt = SHOW_HS;
            end
            SHOW_HS: begin
                tg1 = 1'b1;
                if (page_done) state_nxt = SHOW_WIN;
            end
            SHOW_WIN: begin
                tg1 = 1'b1;
                tg2 = 1'b1;
                if (page_done) state_nxt = SHOW_PB;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) state_nxt = PLAY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            page_secs <= '0;
            secs_left <= '0;
            player    <= '0;
        end else if (accept) begin
            player    <= player_sel;
            secs_left <= GAME_LEN;
            tick_cnt  <= '0;
            page_secs <= '0;
        end else begin
            case (state)
                PLAY: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
                    if (tick_wrap) secs_left <= secs_left - 6'd1;
                end
                COMMIT: begin
                    tick_cnt  <= '0;
                    page_secs <= '0;
                end
                SHOW_PB, SHOW_HS, SHOW_WIN: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
                    if (tick_wrap) page_secs <= page_done ? 6'd0 : page_secs + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Strict comparisons: ties and a zero score leave the records untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) pb[i] <= '0;
            Highest_Score <= '0;
            Player_Won    <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) pb[i] <= '0;
            Highest_Score <= '0;
            Player_Won    <= '0;
        end else if (commit) begin
            if (Current_Score > pb[player]) pb[player] <= Current_Score;
            if (Current_Score > Highest_Score) begin
                Highest_Score <= Current_Score;
                Player_Won    <= {1'b0, player} + 3'd1;
            end
        end
    end

    assign Personel_Best = pb[player];

endmodule

`default_nettype wire

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the Prime-Prediction score datapath.
- Starts a timed round for a selected player and asserts game_timeout when the round expires.
- Commits the finished Current_Score into per-player personal-best and global high-score registers.
- Drives tg1/tg2 to cycle the score display through personal best, high score and winner.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per second tick.
- GAME_SECS, 30, round length in seconds (1..63).
- SHOW_SECS, 2, dwell time in seconds for each result display page (1..63).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start-round request, level-sampled each cycle.
- player_sel  in  2  player index 0..3; latched on an accepted start.
- Current_Score  in  7  live score from the score updater.
- game_timeout  out  1  1 = no round in progress; score updater freezes.
- tg1  out  1  display page select, MSB.
- tg2  out  1  display page select, LSB.
- Personel_Best  out  7  best score of the latched player.
- Highest_Score  out  7  best score over all players.
- Player_Won  out  3  holder of Highest_Score as player number 1..4; 0 = none.
- secs_left  out  6  remaining round seconds.
- busy  out  1  1 while in PLAY or COMMIT.

Behaviour:
- Reset values: state IDLE; game_timeout=1; tg1=0, tg2=0; secs_left=0; busy=0; all personal bests, Highest_Score and Player_Won = 0; tick counter = 0; latched player = 0.
- States: IDLE, PLAY, COMMIT, SHOW_PB (tg=01), SHOW_HS (tg=10), SHOW_WIN (tg=11).
- Start acceptance: start=1 is accepted only in IDLE or any SHOW_* state.
  - On the accepting edge: latch player_sel; secs_left<=GAME_SECS; tick counter<=0; go to PLAY.
  - start is ignored in PLAY and COMMIT.
- PLAY:
  - Outputs: game_timeout=0, tg=00, busy=1.
  - Tick counter counts 0..TICKS_PER_SEC-1 and wraps.
  - On each wrap, secs_left decrements.
  - When the wrap occurs with secs_left==1: secs_left<=0, go to COMMIT.
  - Round length is exactly GAME_SECS*TICKS_PER_SEC cycles from the accepting edge.
- COMMIT: single cycle; game_timeout=1, tg=00, busy=1. Using S = Current_Score sampled in this cycle:
  - If S > PB[player], PB[player]<=S.
  - If S > Highest_Score, Highest_Score<=S and Player_Won<=player+1.
  - Comparisons are strict. Ties and S=0 change nothing.
  - Both updates may occur in the same cycle.
  - Next state: SHOW_PB, with tick counter and page-seconds counter cleared.
- SHOW_*:
  - game_timeout=1, busy=0.
  - Each page lasts SHOW_SECS*TICKS_PER_SEC cycles.
  - Page order: SHOW_PB -> SHOW_HS -> SHOW_WIN -> SHOW_PB, repeating until start is accepted.
- IDLE: game_timeout=1, tg=00.
- Personel_Best: combinational read of PB[latched player]; follows the new value one cycle after a COMMIT update.
- Arithmetic: all score values are 7-bit unsigned with no wrap. The controller never adds to scores.
- Reset at any time (including mid-PLAY or in COMMIT): asynchronously returns everything to reset values. No partial commit takes place.
- The score registers are cleared only by reset, or by clear when the optional feature is compiled in.

Optional Feature:
- Macro: GAME_ROUND_CTRL_CLEAR_EN.
- When defined:
  - Adds input port clear_scores (1 bit).
  - clear_scores=1 in IDLE or any SHOW_* state synchronously zeroes all PBs, Highest_Score and Player_Won. The state is unchanged.
  - If start and clear_scores are both high in the same cycle, clear takes priority and start is ignored that cycle.
  - clear_scores is ignored in PLAY and COMMIT.
- When undefined: no port; scores persist until reset.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, GAME_SECS=3, SHOW_SECS=2.
1. Reset check: after reset deasserts -> game_timeout=1, tg=00, Highest_Score=0, Player_Won=0, secs_left=0.
2. Full round: start pulse with player_sel=2 -> game_timeout=0 for exactly 12 cycles; secs_left steps 3,2,1,0 every 4 cycles. Current_Score=25 at COMMIT -> Personel_Best=25, Highest_Score=25, Player_Won=3. Then tg=01 for 8 cycles, 10 for 8, 11 for 8, then 01 again.
3. Tie and lower score: a later round with player 0 scoring 25 -> Player_Won stays 3, PB[0]=25. Next round with player 0 scoring 10 -> PB[0] stays 25.
4. Start ignored during play: start held high throughout PLAY -> round still ends after 12 cycles. Then start is re-accepted from SHOW_PB on the next edge.
5. Reset mid-round: reset asserted at cycle 5 of PLAY -> immediate game_timeout=1, all scores 0; no commit of Current_Score.
6. Clear feature (GAME_ROUND_CTRL_CLEAR_EN defined): clear_scores and start high together in SHOW_HS -> scores zeroed, state stays SHOW_HS. clear_scores during PLAY -> no effect.
